// File: rtl/ifetch_icache.sv
// ifetch_icache: fetch stage with a direct-mapped one-word-per-line instruction cache.
// Rev 1.0 - initial release.
`default_nettype none

module ifetch_icache #(
  parameter int          ICACHE_INDEX_BITS = 6,
  parameter logic [31:0] RESET_PC          = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_read_or_not,
  output logic [31:0] intru_addr,
  input  logic        if_load_done,
  input  logic [31:0] mem_ctrl_instru_to_if,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  output logic        if_out_valid,
  input  logic        if_out_ready,
  output logic [31:0] if_out_instru,
  output logic [31:0] if_out_pc
);

  localparam int LINES = 1 << ICACHE_INDEX_BITS;
  localparam int TAG_W = 32 - ICACHE_INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] miss_addr;

  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [ICACHE_INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]             pc_tag;
  logic [ICACHE_INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]             fill_tag;
  logic                         hit;
  logic                         slot_free;
  logic                         awaiting;
  logic                         fill;

  assign idx       = pc[ICACHE_INDEX_BITS+1:2];
  assign pc_tag    = pc[31:ICACHE_INDEX_BITS+2];
  assign fill_idx  = miss_addr[ICACHE_INDEX_BITS+1:2];
  assign fill_tag  = miss_addr[31:ICACHE_INDEX_BITS+2];
  assign hit       = line_valid[idx] && (tag_mem[idx] == pc_tag);
  assign slot_free = !if_out_valid || if_out_ready;
  assign awaiting  = (state == MISS) || (state == DRAIN);
  assign fill      = rdy_in && awaiting && if_load_done;

  // Request drops in the done cycle so memctrl never restarts the same read.
  assign if_read_or_not = awaiting && !if_load_done;
  assign intru_addr     = miss_addr;

  // Tag/data storage needs no reset; the valid bits guard it.
  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_ctrl_instru_to_if;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      miss_addr     <= 32'h0;
      line_valid    <= '0;
      if_out_valid  <= 1'b0;
      if_out_instru <= 32'h0;
      if_out_pc     <= 32'h0;
    end else if (rdy_in) begin
      if (fill) begin
        line_valid[fill_idx] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (jump_flag) begin
            if_out_valid <= 1'b0;
            pc           <= jump_addr;
          end else if (slot_free) begin
            if (hit) begin
              if_out_valid  <= 1'b1;
              if_out_instru <= data_mem[idx];
              if_out_pc     <= pc;
              pc            <= pc + 32'd4;
            end else begin
              if_out_valid <= 1'b0;
              miss_addr    <= pc;
              state        <= MISS;
            end
          end
        end
        MISS: begin
          if (if_load_done) begin
            state <= IDLE;
            // A redirect landing on the done cycle discards the fetched word.
            if (jump_flag) begin
              pc <= jump_addr;
            end else begin
              if_out_valid  <= 1'b1;
              if_out_instru <= mem_ctrl_instru_to_if;
              if_out_pc     <= miss_addr;
              pc            <= miss_addr + 32'd4;
            end
          end else if (jump_flag) begin
            pc    <= jump_addr;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (jump_flag) begin
            pc <= jump_addr;
          end
          if (if_load_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_icache.sv
// tb_ifetch_icache: directed scoreboard bench for ifetch_icache with a 6-cycle memctrl model.
`default_nettype none

module tb_ifetch_icache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        if_load_done;
  logic [31:0] mem_ctrl_instru_to_if;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        if_out_valid;
  logic        if_out_ready = 1'b0;
  logic [31:0] if_out_instru;
  logic [31:0] if_out_pc;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  ifetch_icache #(.ICACHE_INDEX_BITS(6), .RESET_PC(32'h0)) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .if_read_or_not        (if_read_or_not),
    .intru_addr            (intru_addr),
    .if_load_done          (if_load_done),
    .mem_ctrl_instru_to_if (mem_ctrl_instru_to_if),
    .jump_flag             (jump_flag),
    .jump_addr             (jump_addr),
    .if_out_valid          (if_out_valid),
    .if_out_ready          (if_out_ready),
    .if_out_instru         (if_out_instru),
    .if_out_pc             (if_out_pc)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0513 : (32'h1300_0000 | a);
  endfunction

  // Memctrl model: done pulses after six consecutive request cycles.
  int unsigned mcnt;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mcnt                  <= 0;
      if_load_done          <= 1'b0;
      mem_ctrl_instru_to_if <= 32'h0;
    end else begin
      if_load_done <= 1'b0;
      if (if_read_or_not && !if_load_done) begin
        if (mcnt == 5) begin
          if_load_done          <= 1'b1;
          mem_ctrl_instru_to_if <= mem_word(intru_addr);
          mcnt                  <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end else begin
        mcnt <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    sb.push_back({a, mem_word(a)});
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!if_out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, {31'h0, if_out_valid}, 32'h1);
  endtask

  task automatic cmp_front(input string tag);
    logic [63:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pc"}, if_out_pc, e[63:32]);
      chk({tag, "_instru"}, if_out_instru, e[31:0]);
    end
  endtask

  task automatic consume(input string tag);
    int n;
    wait_valid(tag, n);
    cmp_front(tag);
    if_out_ready = 1'b1;
    tick();
    if_out_ready = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a);
    int n;
    n = 0;
    while (!(if_read_or_not && intru_addr == a) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_req_addr"}, intru_addr, a);
  endtask

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    chk("rst_valid", {31'h0, if_out_valid}, 32'h0);
    chk("rst_instru", if_out_instru, 32'h0);
    chk("rst_pc", if_out_pc, 32'h0);
    chk("rst_addr", intru_addr, 32'h0);
    chk("rst_req", {31'h0, if_read_or_not}, 32'h0);

    // Cold start miss at 0
    rst_in = 1'b1;
    tick();
    chk("cold_req", {31'h0, if_read_or_not}, 32'h1);
    chk("cold_addr", intru_addr, 32'h0);
    push(32'h0);
    wait_valid("cold", n);
    chk("cold_latency", n, 7);
    cmp_front("cold");
    if_out_ready = 1'b1;
    tick();
    if_out_ready = 1'b0;
    chk("next_req", {31'h0, if_read_or_not}, 32'h1);
    chk("next_addr", intru_addr, 32'h4);
    push(32'h4);
    consume("f4");

    // Stall with an instruction pending at 8
    push(32'h8);
    wait_valid("stall", n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'h0, if_out_valid}, 32'h1);
      chk("stall_pc", if_out_pc, 32'h8);
      chk("stall_instru", if_out_instru, mem_word(32'h8));
      chk("stall_req", {31'h0, if_read_or_not}, 32'h0);
    end
    consume("f8");

    // Redirect to 0 during the miss at 12: drain, then back-to-back hits
    chk("m12_addr", intru_addr, 32'hC);
    jump_flag = 1'b1;
    jump_addr = 32'h0;
    tick();
    jump_flag = 1'b0;
    chk("drain_req", {31'h0, if_read_or_not}, 32'h1);
    chk("drain_addr", intru_addr, 32'hC);
    push(32'h0);
    push(32'h4);
    push(32'h8);
    push(32'hC);
    wait_valid("loop", n);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", {31'h0, if_out_valid}, 32'h1);
      chk("b2b_req", {31'h0, if_read_or_not}, 32'h0);
      cmp_front("b2b");
      if (i < 3) begin
        if_out_ready = 1'b1;
        tick();
      end
    end
    if_out_ready = 1'b0;

    // Redirect from IDLE drops the pending output; conflict 0x100 vs 0x0
    jump_flag = 1'b1;
    jump_addr = 32'h100;
    tick();
    jump_flag = 1'b0;
    chk("jmp_idle_valid", {31'h0, if_out_valid}, 32'h0);
    wait_req("c100", 32'h100);
    push(32'h100);
    consume("c100");
    jump_flag = 1'b1;
    jump_addr = 32'h0;
    tick();
    jump_flag = 1'b0;
    wait_req("c0", 32'h0);
    push(32'h0);
    consume("c0");
    jump_flag = 1'b1;
    jump_addr = 32'h100;
    tick();
    jump_flag = 1'b0;
    wait_req("c100b", 32'h100);
    push(32'h100);
    consume("c100b");

    // PC wrap
    jump_flag = 1'b1;
    jump_addr = 32'hFFFF_FFFC;
    tick();
    jump_flag = 1'b0;
    wait_req("wrap", 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    consume("wrap");
    chk("wrap_next_addr", intru_addr, 32'h0);
    push(32'h0);
    consume("wrap0");

    // Asynchronous reset mid-miss
    jump_flag = 1'b1;
    jump_addr = 32'h40;
    tick();
    jump_flag = 1'b0;
    wait_req("m40", 32'h40);
    tick();
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_req", {31'h0, if_read_or_not}, 32'h0);
    chk("arst_valid", {31'h0, if_out_valid}, 32'h0);
    chk("arst_addr", intru_addr, 32'h0);
    chk("arst_pc", if_out_pc, 32'h0);
    chk("arst_instru", if_out_instru, 32'h0);
    tick();
    rst_in = 1'b1;
    tick();
    chk("restart_req", {31'h0, if_read_or_not}, 32'h1);
    chk("restart_addr", intru_addr, 32'h0);
    push(32'h0);
    consume("restart");
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
